// File: rtl/taxi_sfp_ctrl_pkg.sv
// Shared types for the SFP+ cage manager: per-port state encoding and decode helpers.
package taxi_sfp_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_ABSENT  = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ENABLE  = 3'd2,
      ST_UP      = 3'd3,
      ST_FAULT   = 3'd4,
      ST_LOCKOUT = 3'd5
   } sfp_state_t;

   function automatic logic laser_on(sfp_state_t st);
      return (st == ST_ENABLE) || (st == ST_UP);
   endfunction

endpackage

// File: rtl/taxi_sfp_ctrl_port.sv
// One SFP cage: pin synchronizers, presence debounce, laser sequencing and fault retry/lockout.
//
//  state   | meaning
//  ABSENT  | no module or port disabled; debounce presence
//  SETTLE  | module present, laser off, waiting for module init
//  ENABLE  | laser on, datapath still in reset
//  UP      | laser on, datapath released
//  FAULT   | tx_fault seen, laser off, waiting before retry
//  LOCKOUT | retries exhausted, waiting for software clear
module taxi_sfp_ctrl_port
   import taxi_sfp_ctrl_pkg::*;
#(
   parameter int TIMER_W   = 24,
   parameter int DEBOUNCE  = 16,
   parameter int T_INIT    = 1024,
   parameter int T_TXON    = 256,
   parameter int T_RETRY   = 512,
   parameter int RETRY_MAX = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                npres,
   input  logic                los,
   input  logic                tx_fault,
   input  logic                port_en,
   input  logic [1:0]          rate,
   input  logic                fault_clr,
   output logic                tx_disable,
   output logic [1:0]          rs,
   output logic                xcvr_rst,
   output logic                link_ok,
   output logic                fault_latched,
   output logic [STATE_W-1:0]  state_o
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam logic [DB_W-1:0]    DB_TC    = DB_W'(DEBOUNCE);
   localparam logic [TIMER_W-1:0] INIT_TC  = TIMER_W'(T_INIT - 1);
   localparam logic [TIMER_W-1:0] TXON_TC  = TIMER_W'(T_TXON - 1);
   localparam logic [TIMER_W-1:0] RETRY_TC = TIMER_W'(T_RETRY - 1);
   localparam logic [3:0]         RETRY_LIM = 4'(RETRY_MAX);

   // {tx_fault, los, npres}; reset to "absent, no light, no fault"
   logic [2:0] sync_q1, sync_q2;
   logic       present, los_s, fault_s, abort;

   sfp_state_t         state;
   logic [TIMER_W-1:0] timer;
   logic [DB_W-1:0]    db_cnt;
   logic [3:0]         retry_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 3'b011;
         sync_q2 <= 3'b011;
      end else begin
         sync_q1 <= {tx_fault, los, npres};
         sync_q2 <= sync_q1;
      end
   end

   assign present = !sync_q2[0];
   assign los_s   = sync_q2[1];
   assign fault_s = sync_q2[2];
   assign abort   = !present || !port_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ABSENT;
         timer     <= '0;
         db_cnt    <= '0;
         retry_cnt <= '0;
         rs        <= 2'b00;
      end else begin
         if (state inside {ST_ABSENT, ST_SETTLE})
            rs <= rate;
         timer <= timer + 1'b1;
         if (state != ST_ABSENT)
            db_cnt <= '0;

         if (state != ST_ABSENT && abort) begin
            state <= ST_ABSENT;
            timer <= '0;
         end else begin
            case (state)
               ST_ABSENT: begin
                  retry_cnt <= '0;
                  timer     <= '0;
                  if (!(present && port_en)) begin
                     db_cnt <= '0;
                  end else if (db_cnt == DB_TC) begin
                     db_cnt <= '0;
                     state  <= ST_SETTLE;
                  end else begin
                     db_cnt <= db_cnt + 1'b1;
                  end
               end
               ST_SETTLE: begin
                  if (timer == INIT_TC) begin
                     state <= ST_ENABLE;
                     timer <= '0;
                  end
               end
               ST_ENABLE, ST_UP: begin
                  // fault outranks the ENABLE timer expiring on the same cycle
                  if (fault_s) begin
                     state     <= ST_FAULT;
                     timer     <= '0;
                     retry_cnt <= retry_cnt + 1'b1;
                  end else if (state == ST_ENABLE && timer == TXON_TC) begin
                     state <= ST_UP;
                     timer <= '0;
                  end
               end
               ST_FAULT: begin
                  if (timer == RETRY_TC) begin
                     state <= (retry_cnt == RETRY_LIM) ? ST_LOCKOUT : ST_ENABLE;
                     timer <= '0;
                  end
               end
               ST_LOCKOUT: begin
                  if (fault_clr) begin
                     state <= ST_ABSENT;
                     timer <= '0;
                  end
               end
               default: begin
                  state <= ST_ABSENT;
                  timer <= '0;
               end
            endcase
         end
      end
   end

   assign tx_disable    = !laser_on(state);
   assign xcvr_rst      = (state != ST_UP);
   assign link_ok       = (state == ST_UP) && !los_s;
   assign fault_latched = (state == ST_LOCKOUT);
   assign state_o       = state;

endmodule

// File: rtl/taxi_sfp_ctrl.sv
// Board-level SFP+ cage manager: one independent sequencer per cage.
module taxi_sfp_ctrl
   import taxi_sfp_ctrl_pkg::*;
#(
   parameter int PORTS     = 2,
   parameter int TIMER_W   = 24,
   parameter int DEBOUNCE  = 16,
   parameter int T_INIT    = 1024,
   parameter int T_TXON    = 256,
   parameter int T_RETRY   = 512,
   parameter int RETRY_MAX = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [PORTS-1:0]                sfp_npres,
   input  logic [PORTS-1:0]                sfp_los,
   input  logic [PORTS-1:0]                sfp_tx_fault,
   output logic [PORTS-1:0]                sfp_tx_disable,
   output logic [PORTS-1:0][1:0]           sfp_rs,
   input  logic [PORTS-1:0]                cfg_port_en,
   input  logic [PORTS-1:0][1:0]           cfg_rate,
   input  logic [PORTS-1:0]                cfg_fault_clr,
   output logic [PORTS-1:0]                xcvr_rst,
   output logic [PORTS-1:0]                link_ok,
   output logic [PORTS-1:0]                fault_latched,
   output logic [PORTS-1:0][STATE_W-1:0]   state_o
);

   for (genvar i = 0; i < PORTS; i++) begin : g_port
      taxi_sfp_ctrl_port #(
         .TIMER_W   (TIMER_W),
         .DEBOUNCE  (DEBOUNCE),
         .T_INIT    (T_INIT),
         .T_TXON    (T_TXON),
         .T_RETRY   (T_RETRY),
         .RETRY_MAX (RETRY_MAX)
      ) u_port (
         .clk           (clk),
         .rst_n         (rst_n),
         .npres         (sfp_npres[i]),
         .los           (sfp_los[i]),
         .tx_fault      (sfp_tx_fault[i]),
         .port_en       (cfg_port_en[i]),
         .rate          (cfg_rate[i]),
         .fault_clr     (cfg_fault_clr[i]),
         .tx_disable    (sfp_tx_disable[i]),
         .rs            (sfp_rs[i]),
         .xcvr_rst      (xcvr_rst[i]),
         .link_ok       (link_ok[i]),
         .fault_latched (fault_latched[i]),
         .state_o       (state_o[i])
      );
   end

endmodule

// File: tb/tb_taxi_sfp_ctrl.sv
// Scoreboard bench for taxi_sfp_ctrl: insertion, bounce, fault retry/lockout, removal, rate, async reset.
module tb_taxi_sfp_ctrl;
   import taxi_sfp_ctrl_pkg::*;

   localparam int PORTS = 2;

   localparam int F_STATE = 0;
   localparam int F_TXDIS = 1;
   localparam int F_XRST  = 2;
   localparam int F_LINK  = 3;
   localparam int F_FLAT  = 4;
   localparam int F_RS    = 5;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [PORTS-1:0]           sfp_npres, sfp_los, sfp_tx_fault;
   logic [PORTS-1:0]           sfp_tx_disable;
   logic [PORTS-1:0][1:0]      sfp_rs;
   logic [PORTS-1:0]           cfg_port_en;
   logic [PORTS-1:0][1:0]      cfg_rate;
   logic [PORTS-1:0]           cfg_fault_clr;
   logic [PORTS-1:0]           xcvr_rst, link_ok, fault_latched;
   logic [PORTS-1:0][2:0]      state_o;

   taxi_sfp_ctrl #(
      .PORTS(PORTS), .TIMER_W(16), .DEBOUNCE(4), .T_INIT(8),
      .T_TXON(4), .T_RETRY(6), .RETRY_MAX(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .sfp_npres(sfp_npres), .sfp_los(sfp_los), .sfp_tx_fault(sfp_tx_fault),
      .sfp_tx_disable(sfp_tx_disable), .sfp_rs(sfp_rs),
      .cfg_port_en(cfg_port_en), .cfg_rate(cfg_rate), .cfg_fault_clr(cfg_fault_clr),
      .xcvr_rst(xcvr_rst), .link_ok(link_ok), .fault_latched(fault_latched),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n++;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int due;
      int port;
      int fld;
      int exp;
   } sb_t;

   sb_t sb_q[$];

   task automatic push(input int due, input int p, input int f, input int exp);
      sb_t e;
      e.due = due; e.port = p; e.fld = f; e.exp = exp;
      sb_q.push_back(e);
   endtask

   function automatic int observe(input int p, input int f);
      case (f)
         F_STATE: return int'(state_o[p]);
         F_TXDIS: return int'(sfp_tx_disable[p]);
         F_XRST:  return int'(xcvr_rst[p]);
         F_LINK:  return int'(link_ok[p]);
         F_FLAT:  return int'(fault_latched[p]);
         default: return int'(sfp_rs[p]);
      endcase
   endfunction

   function automatic string fname(input int f);
      case (f)
         F_STATE: return "state";
         F_TXDIS: return "tx_disable";
         F_XRST:  return "xcvr_rst";
         F_LINK:  return "link_ok";
         F_FLAT:  return "fault_latched";
         default: return "sfp_rs";
      endcase
   endfunction

   // pop every entry due at this edge; anything overdue is a miss
   always @(negedge clk) begin
      sb_t keep[$];
      keep = {};
      foreach (sb_q[i]) begin
         if (sb_q[i].due == edge_n)
            chk($sformatf("p%0d_%s@%0d", sb_q[i].port, fname(sb_q[i].fld), sb_q[i].due),
                observe(sb_q[i].port, sb_q[i].fld), sb_q[i].exp);
         else if (sb_q[i].due < edge_n)
            chk($sformatf("p%0d_%s@%0d_missed", sb_q[i].port, fname(sb_q[i].fld), sb_q[i].due),
                edge_n, sb_q[i].due);
         else
            keep.push_back(sb_q[i]);
      end
      sb_q = keep;
   end

   task automatic wait_until(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, ef, er, ec;
      rst_n         = 1'b0;
      sfp_npres     = '1;
      sfp_los       = '1;
      sfp_tx_fault  = '0;
      cfg_port_en   = '1;
      cfg_rate      = '0;
      cfg_fault_clr = '0;
      repeat (3) @(negedge clk);

      for (int p = 0; p < PORTS; p++) begin
         chk($sformatf("rst_p%0d_state", p), int'(state_o[p]), int'(ST_ABSENT));
         chk($sformatf("rst_p%0d_txdis", p), int'(sfp_tx_disable[p]), 1);
         chk($sformatf("rst_p%0d_xrst", p), int'(xcvr_rst[p]), 1);
         chk($sformatf("rst_p%0d_link", p), int'(link_ok[p]), 0);
         chk($sformatf("rst_p%0d_flat", p), int'(fault_latched[p]), 0);
         chk($sformatf("rst_p%0d_rs", p), int'(sfp_rs[p]), 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // rate select tracks request while ABSENT
      cfg_rate[0] = 2'b11;
      e0 = edge_n + 1;
      push(e0, 0, F_RS, 3);
      push(e0, 0, F_STATE, int'(ST_ABSENT));
      wait_until(e0 + 2);

      // presence bounce: 3 cycles low never completes the debounce
      sfp_npres[0] = 1'b0;
      e0 = edge_n + 1;
      for (int k = 2; k <= 8; k += 2) push(e0 + k, 0, F_STATE, int'(ST_ABSENT));
      push(e0 + 6, 0, F_TXDIS, 1);
      wait_until(e0 + 2);
      sfp_npres[0] = 1'b1;
      wait_until(e0 + 10);

      // insertion on both ports together
      sfp_npres = '0;
      sfp_los   = '0;
      e0 = edge_n + 1;
      for (int p = 0; p < PORTS; p++) begin
         push(e0 + 5,  p, F_STATE, int'(ST_ABSENT));
         push(e0 + 6,  p, F_STATE, int'(ST_SETTLE));
         push(e0 + 6,  p, F_TXDIS, 1);
         push(e0 + 13, p, F_STATE, int'(ST_SETTLE));
         push(e0 + 13, p, F_TXDIS, 1);
         push(e0 + 14, p, F_STATE, int'(ST_ENABLE));
         push(e0 + 14, p, F_TXDIS, 0);
         push(e0 + 14, p, F_XRST, 1);
         push(e0 + 17, p, F_STATE, int'(ST_ENABLE));
         push(e0 + 17, p, F_LINK, 0);
         push(e0 + 18, p, F_STATE, int'(ST_UP));
         push(e0 + 18, p, F_XRST, 0);
         push(e0 + 18, p, F_LINK, 1);
      end
      wait_until(e0 + 20);

      // rate request frozen once UP
      cfg_rate[0] = 2'b00;
      e0 = edge_n + 1;
      push(e0, 0, F_RS, 3);
      push(e0 + 3, 0, F_RS, 3);
      wait_until(e0 + 4);

      // persistent tx_fault on port 0: two FAULT entries then LOCKOUT
      sfp_tx_fault[0] = 1'b1;
      ef = edge_n + 1;
      push(ef + 1,  0, F_STATE, int'(ST_UP));
      push(ef + 2,  0, F_STATE, int'(ST_FAULT));
      push(ef + 2,  0, F_TXDIS, 1);
      push(ef + 2,  0, F_XRST, 1);
      push(ef + 2,  0, F_LINK, 0);
      push(ef + 7,  0, F_STATE, int'(ST_FAULT));
      push(ef + 8,  0, F_STATE, int'(ST_ENABLE));
      push(ef + 8,  0, F_TXDIS, 0);
      push(ef + 9,  0, F_STATE, int'(ST_FAULT));
      push(ef + 14, 0, F_STATE, int'(ST_FAULT));
      push(ef + 14, 0, F_FLAT, 0);
      push(ef + 15, 0, F_STATE, int'(ST_LOCKOUT));
      push(ef + 15, 0, F_FLAT, 1);
      push(ef + 15, 0, F_TXDIS, 1);
      push(ef + 2,  1, F_STATE, int'(ST_UP));
      push(ef + 9,  1, F_STATE, int'(ST_UP));
      push(ef + 15, 1, F_STATE, int'(ST_UP));
      push(ef + 15, 1, F_TXDIS, 0);
      push(ef + 15, 1, F_FLAT, 0);
      // clear pulse outside LOCKOUT is ignored by both ports
      wait_until(ef + 5);
      cfg_fault_clr = '1;
      @(negedge clk);
      cfg_fault_clr = '0;
      wait_until(ef + 15);
      sfp_tx_fault[0] = 1'b0;

      // removal of port 1 while UP
      wait_until(ef + 16);
      sfp_npres[1] = 1'b1;
      er = edge_n + 1;
      push(er + 1, 1, F_STATE, int'(ST_UP));
      push(er + 2, 1, F_STATE, int'(ST_ABSENT));
      push(er + 2, 1, F_TXDIS, 1);
      push(er + 2, 1, F_XRST, 1);
      push(er + 2, 1, F_LINK, 0);
      wait_until(er + 2);

      // software clear leaves LOCKOUT; module still seated so it re-sequences
      cfg_fault_clr[0] = 1'b1;
      ec = edge_n + 1;
      @(negedge clk);
      cfg_fault_clr[0] = 1'b0;
      push(ec, 0, F_STATE, int'(ST_ABSENT));
      push(ec, 0, F_FLAT, 0);
      push(ec + 4, 0, F_STATE, int'(ST_ABSENT));
      push(ec + 5, 0, F_STATE, int'(ST_SETTLE));
      push(ec + 13, 0, F_STATE, int'(ST_ENABLE));
      push(ec + 14, 0, F_TXDIS, 0);
      wait_until(ec + 15);

      // async reset mid-ENABLE turns the laser off without a clock edge
      chk("pre_arst_state", int'(state_o[0]), int'(ST_ENABLE));
      rst_n = 1'b0;
      #1;
      chk("arst_txdis", int'(sfp_tx_disable[0]), 1);
      chk("arst_xrst", int'(xcvr_rst[0]), 1);
      chk("arst_state", int'(state_o[0]), int'(ST_ABSENT));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
